// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the ALU core: buffers commands in a small FIFO,
// issues them one at a time with start/done, and returns results or timeouts.
module alu_cmd_sequencer #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_W-1:0]        cmd_op,
  input  logic [DATA_W-1:0]      cmd_a,
  input  logic [DATA_W-1:0]      cmd_b,
  output logic                   alu_start,
  output logic [OP_W-1:0]        alu_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  input  logic                   alu_done,
  input  logic [2*DATA_W-1:0]    alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [OP_W-1:0]        rsp_op,
  output logic [2*DATA_W-1:0]    rsp_result,
  output logic                   rsp_timeout,
  output logic [$clog2(DEPTH):0] fifo_count
);
  // state | meaning
  // IDLE  | waiting for a buffered command; pops the FIFO head into alu_op/a/b
  // ISSUE | single-cycle alu_start pulse
  // WAIT  | waiting for alu_done, abandoned after TIMEOUT cycles
  // RESP  | response held stable until rsp_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam int RES_W = 2 * DATA_W;
  localparam int ENT_W = OP_W + 2 * DATA_W;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
  logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              push, pop, tmo_hit;

  assign cmd_ready = (count_q != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_op, cmd_a, cmd_b};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rsp_op_d      = rsp_op_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          {alu_op_d, alu_a_d, alu_b_d} = mem_q[rd_ptr_q];
          tmo_cnt_d = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A done arriving on the timeout cycle still delivers the real result.
        if (alu_done) begin
          rsp_op_d      = alu_op_q;
          rsp_result_d  = alu_result;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (tmo_hit) begin
          rsp_op_d      = alu_op_q;
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          tmo_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      tmo_cnt_q     <= '0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_op_q      <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      rsp_op_q      <= rsp_op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign alu_start   = (state_q == S_ISSUE);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_op      = rsp_op_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a stub ALU whose done latency is
// programmable and a manual done/result override for stray or late dones.
module tb_alu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_op;
  logic [15:0] rsp_result;
  logic        rsp_timeout;
  logic [2:0]  fifo_count;

  logic        stub_en, stub_done, man_done;
  int          stub_delay, stub_cnt;
  logic [15:0] stub_res, man_res;

  int n_tests = 0;
  int n_fail  = 0;
  int rsp_seen = 0;

  logic [3:0]  sb_op[$];
  logic [15:0] sb_res[$];
  logic        sb_to[$];
  logic [3:0]  pend_op[$];
  logic [7:0]  pend_a[$];
  logic [7:0]  pend_b[$];

  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Stub ALU: opcode 1 multiplies, anything else adds.
  function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    model = (op == 4'd1) ? (16'(a) * 16'(b)) : (16'(a) + 16'(b));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_res  <= '0;
    end else begin
      stub_done <= 1'b0;
      if (alu_start && stub_en) begin
        if (stub_delay <= 1) begin
          stub_done <= 1'b1;
          stub_res  <= model(alu_op, alu_a, alu_b);
        end else begin
          stub_cnt <= stub_delay - 1;
        end
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          stub_done <= 1'b1;
          stub_res  <= model(alu_op, alu_a, alu_b);
        end
      end
    end
  end

  assign alu_done   = stub_done | man_done;
  assign alu_result = man_done ? man_res : stub_res;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    pend_op.push_back(op);
    pend_a.push_back(a);
    pend_b.push_back(b);
  endtask

  // One clock: score any response handshake, offer the next pending command.
  task automatic cycle();
    logic acc;
    if (rsp_valid && rsp_ready) begin
      rsp_seen++;
      if (sb_res.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        check("rsp_op", 32'(rsp_op), 32'(sb_op.pop_front()));
        check("rsp_result", 32'(rsp_result), 32'(sb_res.pop_front()));
        check("rsp_timeout", 32'(rsp_timeout), 32'(sb_to.pop_front()));
      end
    end
    acc = (pend_op.size() != 0) && cmd_ready;
    if (acc) begin
      cmd_valid = 1'b1;
      cmd_op    = pend_op[0];
      cmd_a     = pend_a[0];
      cmd_b     = pend_b[0];
    end else begin
      cmd_valid = 1'b0;
    end
    tick();
    cmd_valid = 1'b0;
    if (acc) begin
      sb_op.push_back(pend_op[0]);
      sb_res.push_back(model(pend_op[0], pend_a[0], pend_b[0]));
      sb_to.push_back(1'b0);
      void'(pend_op.pop_front());
      void'(pend_a.pop_front());
      void'(pend_b.pop_front());
    end
  endtask

  task automatic drain_all(input int budget);
    int n = 0;
    while ((sb_res.size() != 0 || pend_op.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_budget", 32'(sb_res.size() + pend_op.size()), 32'd0);
  endtask

  initial begin
    int acc_cnt;
    int rs0;
    logic ok;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; stub_en = 1'b0; stub_delay = 1; man_done = 1'b0; man_res = '0;

    // Reset values, and no push while reset is held.
    tick(); tick();
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_opab", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("rst_rsp", 32'({rsp_timeout, rsp_op, rsp_result}), 32'd0);
    cmd_valid = 1'b1; cmd_op = 4'd3; cmd_a = 8'h11; cmd_b = 8'h22;
    tick();
    check("rst_no_push", 32'(fifo_count), 32'd0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Single command: minimum latency.
    stub_en = 1'b1; stub_delay = 1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h12; cmd_b = 8'h34;
    check("single_ready", 32'(cmd_ready), 32'd1);
    tick();                                   // N+1
    cmd_valid = 1'b0;
    check("single_n1_count", 32'(fifo_count), 32'd1);
    check("single_n1_start", 32'(alu_start), 32'd0);
    tick();                                   // N+2
    check("single_n2_start", 32'(alu_start), 32'd1);
    check("single_n2_opab", 32'({alu_op, alu_a, alu_b}), 32'h01234);
    check("single_n2_count", 32'(fifo_count), 32'd0);
    tick();                                   // N+3
    check("single_n3_start", 32'(alu_start), 32'd0);
    check("single_n3_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();                                   // N+4
    check("single_n4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_n4_result", 32'(rsp_result), 32'h0046);
    check("single_n4_op", 32'(rsp_op), 32'd0);
    check("single_n4_timeout", 32'(rsp_timeout), 32'd0);
    tick();
    check("single_n5_rsp_valid", 32'(rsp_valid), 32'd0);

    // Fill FIFO with done withheld: 5 of 6 accepted.
    stub_en = 1'b0; acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'(i % 2); cmd_a = 8'(8'h40 + i); cmd_b = 8'(8'h03 + i);
      ok = cmd_ready;
      tick();
      if (ok) begin
        acc_cnt++;
        sb_op.push_back(4'(i % 2));
        sb_res.push_back(model(4'(i % 2), 8'(8'h40 + i), 8'(8'h03 + i)));
        sb_to.push_back(1'b0);
      end
    end
    cmd_valid = 1'b0;
    check("fill_accepted", 32'(acc_cnt), 32'd5);
    check("fill_count", 32'(fifo_count), 32'd4);
    check("fill_ready", 32'(cmd_ready), 32'd0);
    man_done = 1'b1; man_res = 16'h0043;
    tick();
    man_done = 1'b0;
    stub_en = 1'b1; stub_delay = 2;
    drain_all(60);

    // Timeout after exactly 16 WAIT cycles, then a stray done during ISSUE.
    stub_en = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 8'h55; cmd_b = 8'hAA;
    tick();                                   // N+1
    cmd_valid = 1'b0;
    tick();                                   // N+2
    check("tmo_start", 32'(alu_start), 32'd1);
    repeat (16) tick();                       // N+18, last WAIT cycle
    check("tmo_not_early", 32'(rsp_valid), 32'd0);
    tick();                                   // N+19
    check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo_flag", 32'(rsp_timeout), 32'd1);
    check("tmo_result", 32'(rsp_result), 32'd0);
    check("tmo_op", 32'(rsp_op), 32'd2);
    rsp_ready = 1'b1;
    tick();                                   // N+20
    check("tmo_rsp_done", 32'(rsp_valid), 32'd0);
    stub_en = 1'b1; stub_delay = 3;
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 8'h0C; cmd_b = 8'h0B;
    tick();                                   // N+21
    cmd_valid = 1'b0;
    tick();                                   // N+22
    check("stray_issue", 32'(alu_start), 32'd1);
    man_done = 1'b1; man_res = 16'hDEAD;
    tick();                                   // N+23
    man_done = 1'b0;
    check("stray_ignored", 32'(rsp_valid), 32'd0);
    sb_op.push_back(4'd1); sb_res.push_back(16'h0084); sb_to.push_back(1'b0);
    drain_all(20);

    // Response backpressure: held response, no new issue, FIFO fills.
    stub_delay = 1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h7F; cmd_b = 8'h01;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rsp_result", 32'(rsp_result), 32'h0080);
    for (int k = 0; k < 10; k++) begin
      ok = cmd_ready;
      cmd_valid = ok; cmd_op = 4'(k % 2); cmd_a = 8'(8'h21 + k); cmd_b = 8'h11;
      tick();
      cmd_valid = 1'b0;
      if (ok) begin
        sb_op.push_back(4'(k % 2));
        sb_res.push_back(model(4'(k % 2), 8'(8'h21 + k), 8'h11));
        sb_to.push_back(1'b0);
      end
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_result", 32'(rsp_result), 32'h0080);
      check("bp_no_start", 32'(alu_start), 32'd0);
    end
    check("bp_count", 32'(fifo_count), 32'd4);
    check("bp_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();                                   // handshake + 1
    check("b2b_gap1", 32'(alu_start), 32'd0);
    tick();                                   // handshake + 2
    check("b2b_start", 32'(alu_start), 32'd1);
    drain_all(60);

    // Simultaneous push/pop at fifo_count=2, ten commands across the wrap.
    rsp_ready = 1'b0;
    add(4'd0, 8'h01, 8'h02); add(4'd1, 8'h03, 8'h04); add(4'd0, 8'h05, 8'h06);
    for (int w = 0; w < 20 && !rsp_valid; w++) cycle();
    check("pp_rsp_wait", 32'(rsp_valid), 32'd1);
    check("pp_count_before", 32'(fifo_count), 32'd2);
    rsp_ready = 1'b1;
    cycle();
    add(4'd1, 8'h07, 8'h08);
    cycle();
    check("pp_count_same", 32'(fifo_count), 32'd2);
    check("pp_issue", 32'(alu_start), 32'd1);
    for (int j = 0; j < 6; j++) add(4'(j % 2), 8'(8'h90 + j), 8'(8'h0F - j));
    drain_all(120);

    // Reset mid-WAIT with three commands queued.
    stub_en = 1'b0;
    add(4'd0, 8'hA1, 8'h01); add(4'd0, 8'hA2, 8'h02); add(4'd0, 8'hA3, 8'h03); add(4'd0, 8'hA4, 8'h04);
    repeat (6) cycle();
    check("mid_count", 32'(fifo_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_start", 32'(alu_start), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_alu_opab", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("mid_rst_rsp", 32'({rsp_timeout, rsp_op, rsp_result}), 32'd0);
    sb_op.delete(); sb_res.delete(); sb_to.delete();
    pend_op.delete(); pend_a.delete(); pend_b.delete();
    tick(); tick();
    reset = 1'b0;
    stub_en = 1'b1; stub_delay = 1;
    rs0 = rsp_seen;
    repeat (20) cycle();
    check("mid_no_rsp", 32'(rsp_seen - rs0), 32'd0);
    check("mid_idle_count", 32'(fifo_count), 32'd0);
    add(4'd1, 8'h10, 8'h10);
    drain_all(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
